// File: rtl/whistle_confirm.sv
// whistle_confirm: temporal confirmation of per-frame pitch detections.
// Requires CONFIRM_FRAMES consecutive-ish in-band hits with bounded bin drift,
// rides through up to MISS_TOL consecutive misses, then cools down before re-arming.
module whistle_confirm #(
    parameter int NSamples        = 1024,
    parameter int BIN_LO          = 40,
    parameter int BIN_HI          = 120,
    parameter int MAX_DRIFT       = 3,
    parameter int CONFIRM_FRAMES  = 4,
    parameter int MISS_TOL        = 1,
    parameter int COOLDOWN_CYCLES = 1000000,
    localparam int KW             = $clog2(NSamples)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [KW-1:0] pitch_data,
    input  logic          pitch_valid,
    input  logic          pitch_fire,
    output logic          whistle_detected,
    output logic          whistle_pulse,
    output logic [KW-1:0] whistle_bin
);

    localparam int HW = $clog2(CONFIRM_FRAMES + 1);
    localparam int MW = $clog2(MISS_TOL + 2);
    localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [HW-1:0] hit_cnt_r, hit_cnt_nxt_s, hit_inc_s;
    logic [MW-1:0] miss_cnt_r, miss_cnt_nxt_s, miss_inc_s;
    logic [CW-1:0] cd_cnt_r, cd_cnt_nxt_s;
    logic [KW-1:0] last_bin_r, last_bin_nxt_s;
    logic [KW-1:0] bin_r, bin_nxt_s;
    logic          det_r, pulse_r, pulse_nxt_s;
    logic          in_band_s, drift_ok_s;
    logic [KW:0]   diff_s;

    // Frame classification: band check and absolute drift from the last hit bin (no wrap).
    always_comb begin
        in_band_s = pitch_fire && (pitch_data >= KW'(BIN_LO)) && (pitch_data <= KW'(BIN_HI));
        if (pitch_data >= last_bin_r) begin
            diff_s = {1'b0, pitch_data} - {1'b0, last_bin_r};
        end else begin
            diff_s = {1'b0, last_bin_r} - {1'b0, pitch_data};
        end
        drift_ok_s = (diff_s <= (KW+1)'(MAX_DRIFT));
        hit_inc_s  = hit_cnt_r + HW'(1);
        miss_inc_s = miss_cnt_r + MW'(1);
    end

    // Next-state and next-register values for the confirmation FSM.
    always_comb begin
        state_nxt_s    = state_r;
        hit_cnt_nxt_s  = hit_cnt_r;
        miss_cnt_nxt_s = miss_cnt_r;
        cd_cnt_nxt_s   = cd_cnt_r;
        last_bin_nxt_s = last_bin_r;
        bin_nxt_s      = bin_r;
        pulse_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pitch_valid && in_band_s) begin
                    last_bin_nxt_s = pitch_data;
                    bin_nxt_s      = pitch_data;
                    miss_cnt_nxt_s = MW'(0);
                    hit_cnt_nxt_s  = HW'(1);
                    if (CONFIRM_FRAMES == 1) begin
                        state_nxt_s = ST_ACTIVE;
                        pulse_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ARMING;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMING: begin
                if (pitch_valid && in_band_s && drift_ok_s) begin
                    last_bin_nxt_s = pitch_data;
                    bin_nxt_s      = pitch_data;
                    miss_cnt_nxt_s = MW'(0);
                    hit_cnt_nxt_s  = hit_inc_s;
                    if (hit_inc_s == HW'(CONFIRM_FRAMES)) begin
                        state_nxt_s = ST_ACTIVE;
                        pulse_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ARMING;
                    end
                end else if (pitch_valid) begin
                    if (miss_inc_s > MW'(MISS_TOL)) begin
                        state_nxt_s    = ST_IDLE;
                        hit_cnt_nxt_s  = HW'(0);
                        miss_cnt_nxt_s = MW'(0);
                    end else begin
                        miss_cnt_nxt_s = miss_inc_s;
                    end
                end else begin
                    state_nxt_s = ST_ARMING;
                end
            end
            ST_ACTIVE: begin
                if (pitch_valid && in_band_s && drift_ok_s) begin
                    last_bin_nxt_s = pitch_data;
                    bin_nxt_s      = pitch_data;
                    miss_cnt_nxt_s = MW'(0);
                end else if (pitch_valid) begin
                    if (miss_inc_s > MW'(MISS_TOL)) begin
                        state_nxt_s    = ST_COOLDOWN;
                        cd_cnt_nxt_s   = CW'(COOLDOWN_CYCLES - 1);
                        hit_cnt_nxt_s  = HW'(0);
                        miss_cnt_nxt_s = MW'(0);
                    end else begin
                        miss_cnt_nxt_s = miss_inc_s;
                    end
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_COOLDOWN: begin
                // Frames are deliberately ignored here; only the countdown runs.
                if (cd_cnt_r == CW'(0)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cd_cnt_nxt_s = cd_cnt_r - CW'(1);
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                hit_cnt_nxt_s  = HW'(0);
                miss_cnt_nxt_s = MW'(0);
                cd_cnt_nxt_s   = CW'(0);
            end
        endcase
    end

    // State, counters and registered outputs; reset wins over any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hit_cnt_r  <= HW'(0);
            miss_cnt_r <= MW'(0);
            cd_cnt_r   <= CW'(0);
            last_bin_r <= KW'(0);
            bin_r      <= KW'(0);
            det_r      <= 1'b0;
            pulse_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hit_cnt_r  <= hit_cnt_nxt_s;
            miss_cnt_r <= miss_cnt_nxt_s;
            cd_cnt_r   <= cd_cnt_nxt_s;
            last_bin_r <= last_bin_nxt_s;
            bin_r      <= bin_nxt_s;
            det_r      <= (state_nxt_s == ST_ACTIVE);
            pulse_r    <= pulse_nxt_s;
        end
    end

    assign whistle_detected = det_r;
    assign whistle_pulse    = pulse_r;
    assign whistle_bin      = bin_r;

endmodule

// File: doc/whistle_confirm.md
# whistle_confirm

Temporal confirmation stage directly downstream of the FFT pitch detector. It consumes one peak-bin result per FFT frame. It asserts a clean, debounced whistle output only after a configurable number of frames land inside a frequency band with bounded bin drift. It then holds that output through short dropouts and enforces a cooldown before re-arming. Its output replaces the raw per-frame `fire` as the board-level `whistle_detected`.

## Interface
- `NSamples`, 1024: FFT length; bin width `KW = $clog2(NSamples)`.
- `BIN_LO`, 40: lowest accepted peak bin (inclusive).
- `BIN_HI`, 120: highest accepted peak bin (inclusive).
- `MAX_DRIFT`, 3: max |bin − previous hit bin| for a frame to count as a hit (ARMING/ACTIVE only).
- `CONFIRM_FRAMES`, 4: hits needed to enter ACTIVE; ≥1.
- `MISS_TOL`, 1: consecutive misses tolerated; the (MISS_TOL+1)-th consecutive miss ends ARMING/ACTIVE.
- `COOLDOWN_CYCLES`, 1000000: `clk` cycles spent in COOLDOWN; ≥1.

Ports:
- `clk`  in  1: single clock, the FFT-side clock.
- `reset`  in  1: synchronous, active-high.
- `pitch_data`  in  KW: peak bin of the current frame.
- `pitch_valid`  in  1: one-cycle frame strobe; each high cycle is one frame.
- `pitch_fire`  in  1: frame magnitude exceeded the detector threshold; sampled only with `pitch_valid`.
- `whistle_detected`  out  1: level, high exactly while in ACTIVE.
- `whistle_pulse`  out  1: one-cycle strobe on entry to ACTIVE.
- `whistle_bin`  out  KW: last hit bin; 0 until the first hit after reset.

## Operation
- Frame classification, evaluated only when `pitch_valid`=1:
  - in_band = `pitch_fire` && BIN_LO ≤ `pitch_data` ≤ BIN_HI.
  - In IDLE, hit = in_band.
  - In ARMING/ACTIVE, hit = in_band && |`pitch_data` − `last_bin`| ≤ MAX_DRIFT.
  - Compute the difference unsigned at KW+1 bits, no wrap.
  - miss = not hit.
- On every hit: `last_bin` ← `pitch_data`, `whistle_bin` ← `pitch_data`, miss_cnt ← 0.
- States:
  - **IDLE**
    - hit → hit_cnt ← 1. If CONFIRM_FRAMES=1, go to ACTIVE with pulse; else go to ARMING.
    - miss → no change.
  - **ARMING**
    - hit → hit_cnt+1. On reaching CONFIRM_FRAMES, go to ACTIVE and pulse.
    - miss → miss_cnt+1. If it exceeds MISS_TOL, go to IDLE and clear hit_cnt and miss_cnt. Else stay; hit_cnt is preserved.
  - **ACTIVE**
    - hit → stay.
    - miss → miss_cnt+1. If it exceeds MISS_TOL, go to COOLDOWN, load cooldown counter with COOLDOWN_CYCLES−1, and clear both counts.
  - **COOLDOWN**
    - Frames are ignored: no classification, no `whistle_bin` update.
    - Counter decrements each cycle; at 0, go to IDLE.
- Counter widths: hit_cnt `$clog2(CONFIRM_FRAMES+1)`, miss_cnt `$clog2(MISS_TOL+2)`. Neither counter can overflow given the transitions above.
- `whistle_bin` retains its value through COOLDOWN and IDLE.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, `whistle_detected`=0, `whistle_pulse`=0, `whistle_bin`=0, all counters 0.
- Latency: the frame on cycle t that completes confirmation gives `whistle_detected`=1 and `whistle_pulse`=1 at t+1. The pulse is low at t+2.
- The frame on cycle t that ends ACTIVE gives `whistle_detected`=0 at t+1.
- COOLDOWN lasts exactly COOLDOWN_CYCLES cycles. A frame arriving on the first IDLE cycle is classified.
- Back-to-back `pitch_valid` on consecutive cycles: each cycle is processed as an independent frame.
- `pitch_valid`=0: no state change except the COOLDOWN countdown.
- `reset` mid-operation: all registers return to reset values on the next edge. `reset` has priority over any simultaneous frame.

## Test plan
- **Confirmation:** reset, then frames bins 60, 61, 62, 61 with fire=1 → `whistle_pulse` for exactly one cycle after the 4th frame; `whistle_detected`=1; `whistle_bin`=61.
- **Rejection:**
  - Frames 60, 60, 130 (out of band), 200 → back in IDLE after the 130,200 pair; no pulse.
  - Frames 60, 61, 70 (drift 9) → counted as a miss, not a hit.
- **Dropout tolerance:** in ACTIVE, send one frame with fire=0, then bin 62 → `whistle_detected` stays 1. Then two consecutive misses → drops to 0 one cycle after the second miss.
- **Cooldown:** with COOLDOWN_CYCLES=8, after ACTIVE ends, send 4 valid in-band frames during cooldown → ignored, `whistle_bin` unchanged. An in-band frame on cycle 8 after entry starts ARMING (hit_cnt=1).
- **Edges:**
  - CONFIRM_FRAMES=1: a single in-band frame → pulse next cycle.
  - Bins exactly BIN_LO=40 and BIN_HI=120 → accepted.
  - Bins 39 and 121 → misses.
- **Reset and back-to-back:** assert `reset` during ACTIVE together with a valid hit → all outputs 0 next cycle. Send 4 hits on 4 consecutive cycles → pulse on the cycle after the 4th.
